// File: rtl/rf_pkg.sv
// rf_pkg: shared clear-FSM state encoding and default register-file dimensions
package rf_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
endpackage

// File: rtl/rf_clear_ctrl.sv
// rf_clear_ctrl: clear sequencer walking clr_addr 0..DEPTH-1 once per clr_req (clk, rst_n, clr_req -> busy, clr_en, clr_addr)
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);
  clr_state_e state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    state_nxt   = state == IDLE ? (clr_req ? CLEAR : IDLE) : (&clr_cnt ? IDLE : CLEAR);
    clr_cnt_nxt = state == CLEAR ? clr_cnt + ADDR_W'(1) : '0;
  end
  assign busy     = state == CLEAR;
  assign clr_en   = state == CLEAR;
  assign clr_addr = clr_cnt;
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: 1W/2R register file, registered write-first reads, sequenced clear (clk, rst_n, we/write_addr/write_data, read_addrN -> read_dataN, clr_req -> busy, wr_err)
module reg_file_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZERO  = ZERO_REG != 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en, wr_commit, wr_drop;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd1_nxt, rd2_nxt;
  rf_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );
  assign wr_drop   = we && (busy || clr_req);
  assign wr_commit = we && !busy && !clr_req && !(ZERO && write_addr == '0);
  assign rd1_nxt = (ZERO && read_addr1 == '0) || (clr_en && read_addr1 == clr_addr) ? '0 :
                   (wr_commit && read_addr1 == write_addr) ? write_data : mem[read_addr1];
  assign rd2_nxt = (ZERO && read_addr2 == '0) || (clr_en && read_addr2 == clr_addr) ? '0 :
                   (wr_commit && read_addr2 == write_addr) ? write_data : mem[read_addr2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      wr_err     <= 1'b0;
    end else begin
      if (clr_en) mem[clr_addr] <= '0;
      else if (wr_commit) mem[write_addr] <= write_data;
      read_data1 <= rd1_nxt;
      read_data2 <= rd2_nxt;
      wr_err     <= wr_drop;
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: scoreboard bench driving a plain and a zero-register instance against a behavioural model
module tb_reg_file_param;
  logic       clk = 0;
  logic       rst_n = 0, we = 0, clr_req = 0;
  logic [2:0] write_addr = 0, read_addr1 = 0, read_addr2 = 0;
  logic [7:0] write_data = 0;
  logic [7:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic       busy0, busy1, err0, err1;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic [1:0][7:0] rd1;
    logic [1:0][7:0] rd2;
    logic [1:0]      busy;
    logic [1:0]      err;
  } exp_t;
  exp_t q[$];
  logic [7:0] m[2][8];
  int bl[2], ci[2];
  always #5 clk = ~clk;
  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_data1(rd1_0), .read_data2(rd2_0),
    .clr_req(clr_req), .busy(busy0), .wr_err(err0)
  );
  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_data1(rd1_1), .read_data2(rd2_1),
    .clr_req(clr_req), .busy(busy1), .wr_err(err1)
  );
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd1_z0", rd1_0, e.rd1[0]);
      chk("rd2_z0", rd2_0, e.rd2[0]);
      chk("busy_z0", {7'd0, busy0}, {7'd0, e.busy[0]});
      chk("wr_err_z0", {7'd0, err0}, {7'd0, e.err[0]});
      chk("rd1_z1", rd1_1, e.rd1[1]);
      chk("rd2_z1", rd2_1, e.rd2[1]);
      chk("busy_z1", {7'd0, busy1}, {7'd0, e.busy[1]});
      chk("wr_err_z1", {7'd0, err1}, {7'd0, e.err[1]});
    end
  end
  function automatic logic [7:0] mrd(input int d, input bit bz, input bit com,
                                     input logic [2:0] a, input logic [2:0] wa, input logic [7:0] wd);
    if (d == 1 && a == 0) return 8'h00;
    if (bz && a == ci[d]) return 8'h00;
    if (com && a == wa) return wd;
    return m[d][a];
  endfunction
  task automatic step(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a1, input logic [2:0] a2, input bit c);
    exp_t e;
    @(negedge clk);
    rst_n = r; we = w; write_addr = wa; write_data = wd;
    read_addr1 = a1; read_addr2 = a2; clr_req = c;
    for (int d = 0; d < 2; d++) begin
      bit bz, com;
      bz  = bl[d] > 0;
      com = w && !bz && !c && !(d == 1 && wa == 0);
      if (!r) begin
        for (int i = 0; i < 8; i++) m[d][i] = 8'h00;
        bl[d] = 0; ci[d] = 0;
        e.rd1[d] = 0; e.rd2[d] = 0; e.busy[d] = 0; e.err[d] = 0;
      end else begin
        e.rd1[d] = mrd(d, bz, com, a1, wa, wd);
        e.rd2[d] = mrd(d, bz, com, a2, wa, wd);
        e.err[d] = w && (bz || c);
        if (bz) begin
          m[d][ci[d]] = 8'h00;
          ci[d] = (ci[d] + 1) % 8;
          bl[d]--;
        end else if (c) begin
          bl[d] = 8;
          ci[d] = 0;
        end
        if (com) m[d][wa] = wd;
        e.busy[d] = bl[d] > 0;
      end
    end
    q.push_back(e);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      bl[d] = 0; ci[d] = 0;
      for (int i = 0; i < 8; i++) m[d][i] = 8'hxx;
    end
    step(0, 1, 3, 8'h99, 0, 1, 1);
    step(0, 0, 0, 0, 2, 3, 0);
    step(1, 1, 0, 8'h55, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 8'hAA, 1, 0, 0);
    step(1, 1, 0, 8'hFF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 8'h10 + 8'(i), 3'(i), 3'(7 - i), 0);
    step(1, 0, 0, 0, 0, 7, 1);
    step(1, 0, 0, 0, 0, 7, 1);
    step(1, 1, 6, 8'hEE, 1, 6, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 3'(i), 3'(i + 1), 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 3'(i), 3'(7 - i), 0);
    for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 8'h20 + 8'(i), 3'(i), 3'(i), 0);
    step(1, 0, 0, 0, 5, 4, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 5, 4, 0);
    step(0, 0, 0, 0, 5, 4, 0);
    step(1, 1, 5, 8'h3C, 5, 4, 0);
    step(1, 0, 0, 0, 5, 5, 0);
    step(1, 1, 2, 8'h44, 2, 2, 0);
    step(1, 1, 2, 8'h77, 2, 2, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 2, 3'(i), 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) != 0, $urandom_range(1) == 1, 3'($urandom), 8'($urandom),
           3'($urandom), 3'($urandom), $urandom_range(15) == 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 3'(i), 3'(i + 3), 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port write_addr  input  ADDR_W  write address.
REQ-008 SHALL have port write_data  input  DATA_W  write data.
REQ-009 SHALL have ports read_addr1, read_addr2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-010 SHALL have ports read_data1, read_data2  output  DATA_W  registered read data, ports 1 and 2.
REQ-011 SHALL have port clr_req  input  1  request to clear all registers.
REQ-012 SHALL have port busy  output  1  clear sequence in progress.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse when a write is dropped.

Function
REQ-014 SHALL register reads: read_dataN at edge k+1 reflects read_addrN sampled at edge k (1-cycle latency), both ports independent.
REQ-015 SHALL commit a write on the edge where we=1 and busy=0, except when clr_req=1 in the same cycle (see REQ-020).
REQ-016 SHALL be write-first: when a committed write and a read share an address in the same cycle, read_dataN next cycle = write_data; this bypass applies to both ports.
REQ-017 SHALL, with ZERO_REG=1, ignore writes to address 0 without asserting wr_err, always return 0 for address 0, and not bypass writes to address 0.
REQ-018 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on clr_req=1; in CLEAR, clear one register per cycle via counter clr_cnt starting at 0; CLEAR -> IDLE after clearing DEPTH-1.
REQ-019 SHALL hold busy=1 for exactly DEPTH cycles, starting the cycle after clr_req is accepted.
REQ-020 SHALL drop a write that coincides with clr_req=1 in IDLE or with busy=1, and pulse wr_err=1 on the following cycle.
REQ-021 SHALL ignore clr_req while in CLEAR; no restart and no extension of the sequence.
REQ-022 SHALL serve reads during CLEAR from current array contents: cleared entries read 0, uncleared entries read old data; a read of the entry being cleared this cycle returns 0.
REQ-023 SHALL wrap clr_cnt to 0 at the end of CLEAR; no out-of-range index.

Reset
REQ-024 SHALL, on an edge with rst_n=0, clear all DEPTH registers to 0, set read_data1/2=0, busy=0, wr_err=0, state=IDLE, clr_cnt=0.
REQ-025 SHALL abort a CLEAR sequence immediately on reset; it does not resume after reset deasserts.
REQ-026 SHALL give reset priority over we and clr_req in the same cycle.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, CLEAR) and default DATA_W/ADDR_W constants in shared package rf_pkg.
REQ-028 SHALL implement the FSM and clr_cnt in sub-module rf_clear_ctrl, which outputs busy, clr_en and clr_addr; the array, read ports and bypass live in the top module.

Verification
REQ-029 SHALL cover basic write/read: write 0x55 to addr 0, then read addr 0 on both ports -> both read_data = 0x55 one cycle after the read address is applied.
REQ-030 SHALL cover bypass: write 0xAA to addr 1 while read_addr1=1 in the same cycle -> read_data1=0xAA next cycle.
REQ-031 SHALL cover clear: fill addrs 0-7 with 0x10..0x17, pulse clr_req -> busy high 8 cycles; write during busy -> wr_err pulses once and the array is all 0 afterwards.
REQ-032 SHALL cover ZERO_REG=1: write 0xFF to addr 0 -> read 0x00, wr_err=0.
REQ-033 SHALL cover reset mid-clear: assert rst_n=0 at clear cycle 3 -> all outputs 0, busy=0, then a write of 0x3C to addr 5 reads back 0x3C.
REQ-034 SHALL cover clr_req coinciding with a write of 0x77 to addr 2 -> write dropped, wr_err=1, addr 2 reads 0 after clear.
